mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_rr_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared defaults, state encoding and index-width helper for mem_arbiter
package mem_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 8;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin search starting just after last owner
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = idx_w(NUM_REQ_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Offsets 1..N visit every index once, ending on last itself.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin RAM arbiter with lockable ownership and 1-cycle responses
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ-1:0]        req_wren,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int IW = idx_w(NUM_REQ);

    logic [0:0]         state;
    logic [IW-1:0]      last_owner;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] hold_mask;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] rsp_pend;
    logic               rsp_wr;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req  (req_valid),
        .last (last_owner),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign hold_mask = NUM_REQ'(1) << last_owner;

    // Grants are gated by clear so nothing leaks onto the RAM port during reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_owner;
        gnt_any = 1'b0;
        if (clear) begin
            if (state == ST_HOLD) begin
                gnt     = req_valid & hold_mask;
                gnt_any = |(req_valid & hold_mask);
            end else begin
                gnt     = pick_gnt;
                gnt_idx = pick_idx;
                gnt_any = pick_any;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_wren = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_addr = req_addr[i*ADDR_W +: ADDR_W];
                mem_din  = req_wdata[i*DATA_W +: DATA_W];
                mem_wren = req_wren[i];
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= ST_ARB;
            last_owner <= IW'(NUM_REQ - 1);
            rsp_pend   <= '0;
            rsp_wr     <= 1'b0;
        end else begin
            rsp_pend <= gnt;
            rsp_wr   <= mem_wren;
            if (gnt_any) begin
                last_owner <= gnt_idx;
                state      <= req_lock[gnt_idx] ? ST_HOLD : ST_ARB;
            end
        end
    end

    assign req_gnt   = gnt;
    assign rsp_valid = rsp_pend;
    assign rsp_rdata = (|rsp_pend && !rsp_wr) ? mem_dout : '0;

endmodule
